// File: rtl/pip_reg_fd_ctl.sv
// pip_reg_fd_ctl: Fetch->Decode pipeline register with stall (en_i), flush/bubble and valid bit.
// Define PIP_REG_PERF_CNT_EN to add saturating stall/flush performance counters.
module pip_reg_fd_ctl #(
  parameter int PC_WIDTH = 32,
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int SIDE_WIDTH = 1,
  parameter logic [INSTRUCTION_WIDTH-1:0] NOP_INSTR = 32'h0000_0013,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         en_i,
  input  logic                         flush_i,
  input  logic                         validF_i,
  input  logic [PC_WIDTH-1:0]          pcF_i,
  input  logic [INSTRUCTION_WIDTH-1:0] InstrF_i,
  input  logic [PC_WIDTH-1:0]          pcPlus4F_i,
  input  logic [SIDE_WIDTH-1:0]        sideF_i,
  output logic                         validD_o,
  output logic [PC_WIDTH-1:0]          pcD_o,
  output logic [INSTRUCTION_WIDTH-1:0] InstrD_o,
  output logic [PC_WIDTH-1:0]          pcPlus4D_o,
  output logic [SIDE_WIDTH-1:0]        sideD_o,
  output logic [COUNT_WIDTH-1:0]       stallCnt_o,
  output logic [COUNT_WIDTH-1:0]       flushCnt_o
);
  logic                         valid_q, valid_d;
  logic [PC_WIDTH-1:0]          pc_q, pc_d, pc4_q, pc4_d;
  logic [INSTRUCTION_WIDTH-1:0] instr_q, instr_d;
  logic [SIDE_WIDTH-1:0]        side_q, side_d;

  // flush overrides a stall; a bubble looks exactly like the reset state
  always_comb begin
    valid_d = flush_i ? 1'b0 : en_i ? validF_i : valid_q;
    pc_d    = flush_i ? '0 : en_i ? pcF_i : pc_q;
    instr_d = flush_i ? NOP_INSTR : en_i ? InstrF_i : instr_q;
    pc4_d   = flush_i ? '0 : en_i ? pcPlus4F_i : pc4_q;
    side_d  = flush_i ? '0 : en_i ? sideF_i : side_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
      pc4_q   <= '0;
      side_q  <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      side_q  <= side_d;
    end
  end

  assign validD_o   = valid_q;
  assign pcD_o      = pc_q;
  assign InstrD_o   = instr_q;
  assign pcPlus4D_o = pc4_q;
  assign sideD_o    = side_q;

`ifdef PIP_REG_PERF_CNT_EN
  logic [COUNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic                   stall_inc, flush_inc;

  // counters saturate at all-ones instead of wrapping
  always_comb begin
    stall_inc   = !flush_i && !en_i && valid_q && !(&stall_cnt_q);
    flush_inc   = flush_i && !(&flush_cnt_q);
    stall_cnt_d = stall_cnt_q + {{(COUNT_WIDTH-1){1'b0}}, stall_inc};
    flush_cnt_d = flush_cnt_q + {{(COUNT_WIDTH-1){1'b0}}, flush_inc};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stallCnt_o = stall_cnt_q;
  assign flushCnt_o = flush_cnt_q;
`else
  assign stallCnt_o = '0;
  assign flushCnt_o = '0;
`endif
endmodule

// File: doc/pip_reg_fd_ctl.md
Name: pip_reg_fd_ctl

Overview:
- Parametrised Fetch->Decode pipeline register.
- Adds synchronous reset, flush/bubble insertion, a valid bit and a generic side-band payload to the plain enable/freeze register.
- Sits between the fetch stage and the decode stage.
- Driven by the hazard unit: en_i is the stall control, flush_i is driven on a taken branch/jump.

Parameters:
- PC_WIDTH, 32, width of the PC and PC+4 fields
- INSTRUCTION_WIDTH, 32, width of the instruction field
- SIDE_WIDTH, 1, width of the generic side-band payload (e.g. predicted-taken bit); must be >= 1
- NOP_INSTR, 32'h0000_0013, instruction value presented in Decode for a bubble (addi x0,x0,0)
- COUNT_WIDTH, 16, width of the performance counters (used only with the optional feature)

Ports:
- clk_i  input  1  clock; all state updates on the rising edge
- rst_i  input  1  synchronous, active-high reset
- en_i  input  1  1 = capture Fetch values; 0 = freeze (stall)
- flush_i  input  1  1 = load a bubble on the next edge
- validF_i  input  1  Fetch slot holds a real instruction
- pcF_i  input  PC_WIDTH  Fetch PC
- InstrF_i  input  INSTRUCTION_WIDTH  Fetch instruction
- pcPlus4F_i  input  PC_WIDTH  Fetch PC+4
- sideF_i  input  SIDE_WIDTH  Fetch side-band payload
- validD_o  output  1  Decode slot valid
- pcD_o  output  PC_WIDTH  Decode PC
- InstrD_o  output  INSTRUCTION_WIDTH  Decode instruction
- pcPlus4D_o  output  PC_WIDTH  Decode PC+4
- sideD_o  output  SIDE_WIDTH  Decode side-band payload
- stallCnt_o  output  COUNT_WIDTH  stall-cycle count (PIP_REG_PERF_CNT_EN only)
- flushCnt_o  output  COUNT_WIDTH  flush count (PIP_REG_PERF_CNT_EN only)

Behaviour:
- All outputs registered; nothing combinational from input to output. Latency Fetch->Decode is 1 cycle.
- Update priority per edge: rst_i > flush_i > en_i.
- rst_i=1:
  - validD_o=0, InstrD_o=NOP_INSTR.
  - pcD_o, pcPlus4D_o, sideD_o = 0.
  - Counters = 0.
- flush_i=1 (rst_i=0): bubble load, identical to the reset values except the counters.
  - validD_o=0, InstrD_o=NOP_INSTR.
  - pcD_o, pcPlus4D_o, sideD_o = 0.
  - Applies regardless of en_i: a flush overrides a stall.
- en_i=1, flush_i=0: capture all Fetch fields, validD_o <= validF_i.
- en_i=0, flush_i=0: every output holds its previous value, including validD_o.
- Bubble encoding: validF_i=0 with en_i=1 captures the Fetch fields as presented. Downstream qualifies on validD_o only; InstrD_o is not forced to NOP in this case.
- Mid-operation reset: a reset asserted during a stall or a flush still produces the full reset state on the next edge. No state survives it.
- Power-up: outputs are undefined until the first edge with rst_i=1.

Optional Feature:
- Macro: PIP_REG_PERF_CNT_EN.
- With the macro defined:
  - stallCnt_o increments on every edge with rst_i=0, flush_i=0, en_i=0, validD_o=1, i.e. a real instruction held.
  - flushCnt_o increments on every edge with rst_i=0, flush_i=1.
  - Both counters are COUNT_WIDTH bits, saturate at all-ones (no wrap) and clear only on rst_i.
- Without the macro:
  - Counter logic is not generated.
  - stallCnt_o and flushCnt_o are tied to 0.
  - Ports remain present so the port list is identical in both builds.

Test Plan:
- Reset: rst_i=1 for 2 cycles with arbitrary inputs -> validD_o=0, InstrD_o=32'h00000013, pcD_o=0, pcPlus4D_o=0, sideD_o=0, counters=0.
- Normal flow: en_i=1; pcF_i=0x100, InstrF_i=0x00A00093, pcPlus4F_i=0x104, validF_i=1, sideF_i=1 -> after 1 edge, Decode outputs equal those values and validD_o=1.
- Stall: after the load above, en_i=0 for 3 cycles while Fetch inputs change to 0x200/0xDEADBEEF -> Decode outputs remain 0x100/0x00A00093/0x104 for all 3 cycles. With PIP_REG_PERF_CNT_EN, stallCnt_o=3.
- Flush during stall: en_i=0, flush_i=1 for one edge -> validD_o=0, InstrD_o=0x00000013, pcD_o=0, sideD_o=0. With PIP_REG_PERF_CNT_EN, flushCnt_o increments by 1 and stallCnt_o is unchanged.
- Priority: rst_i=1, flush_i=1, en_i=1 on the same edge -> reset state, counters 0 (flushCnt_o does not increment).
- Saturation (PIP_REG_PERF_CNT_EN, COUNT_WIDTH=4): valid instruction held, en_i=0 for 20 cycles -> stallCnt_o reaches 15 and stays at 15. Without the macro, both counters read 0 throughout.
